// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA pixel timing: sync levels, visible flag, coordinates, strobes.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int H_DISPLAY         = 640,
  parameter int H_FRONT           = 16,
  parameter int H_SYNC            = 96,
  parameter int H_BACK            = 48,
  parameter int V_DISPLAY         = 480,
  parameter int V_FRONT           = 10,
  parameter int V_SYNC            = 2,
  parameter int V_BACK            = 33,
  parameter int HSYNC_ACTIVE_HIGH = 0,
  parameter int VSYNC_ACTIVE_HIGH = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        display_on,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  localparam int C_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int C_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (C_H_TOTAL > 1024) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (C_V_TOTAL > 1024) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end

  localparam logic [9:0]  C_H_LAST   = 10'(C_H_TOTAL - 1);
  localparam logic [9:0]  C_V_LAST   = 10'(C_V_TOTAL - 1);
  // Window bounds are 11 bits wide so an edge landing exactly on 1024 still compares correctly.
  localparam logic [10:0] C_H_DISP   = 11'(H_DISPLAY);
  localparam logic [10:0] C_V_DISP   = 11'(V_DISPLAY);
  localparam logic [10:0] C_HS_START = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] C_HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] C_VS_START = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] C_VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic        C_HS_ON    = 1'(HSYNC_ACTIVE_HIGH != 0);
  localparam logic        C_VS_ON    = 1'(VSYNC_ACTIVE_HIGH != 0);

  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        display_on_q, display_on_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        vblank_start_q, vblank_start_d;

  logic [10:0] h_ext;
  logic [10:0] v_ext;

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    frame_count_d = frame_count_q;

    if (ce) begin
      if (h_q == C_H_LAST) begin
        h_d = '0;
        if (v_q == C_V_LAST) begin
          v_d           = '0;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    // Levels and strobes derive from the next coordinates so they line up with hpos/vpos.
    h_ext = {1'b0, h_d};
    v_ext = {1'b0, v_d};

    display_on_d   = (h_ext < C_H_DISP) && (v_ext < C_V_DISP);
    hsync_d        = ((h_ext >= C_HS_START) && (h_ext < C_HS_END)) ? C_HS_ON : ~C_HS_ON;
    vsync_d        = ((v_ext >= C_VS_START) && (v_ext < C_VS_END)) ? C_VS_ON : ~C_VS_ON;
    line_start_d   = ce && (h_d == 10'd0);
    frame_start_d  = line_start_d && (v_d == 10'd0);
    vblank_start_d = line_start_d && (v_ext == C_V_DISP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q            <= '0;
      v_q            <= '0;
      frame_count_q  <= '0;
      display_on_q   <= 1'b1;
      hsync_q        <= ~C_HS_ON;
      vsync_q        <= ~C_VS_ON;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      h_q            <= h_d;
      v_q            <= v_d;
      frame_count_q  <= frame_count_d;
      display_on_q   <= display_on_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign hpos         = h_q;
  assign vpos         = v_q;
  assign frame_count  = frame_count_q;
  assign display_on   = display_on_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Pixel timing generator for the VGA display pipeline. Produces hsync/vsync, the visible-area flag and the pixel coordinates that the pattern and sprite renderer uses to compute colour each clock. Also generates registered line, frame and vblank strobes plus a frame counter, so downstream logic can update sprite state once per frame without comparing coordinates itself. It sits directly upstream of the renderer and drives the TinyVGA PMOD sync pins through it.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_ACTIVE_HIGH, 0, 0 means hsync is active-low
VSYNC_ACTIVE_HIGH, 0, 0 means vsync is active-low

Ports:
clk  in  1  pixel clock, 25.175 MHz nominal
rst_n  in  1  asynchronous, active-low reset
ce  in  1  pixel advance enable; counters hold while low
hpos  out  10  current column, 0..H_TOTAL-1
vpos  out  10  current line, 0..V_TOTAL-1
display_on  out  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
hsync  out  1  horizontal sync at the configured polarity
vsync  out  1  vertical sync at the configured polarity
line_start  out  1  one-clk strobe: counters just advanced onto hpos==0
frame_start  out  1  one-clk strobe: counters just advanced onto (0,0)
vblank_start  out  1  one-clk strobe: counters just advanced onto (0,V_DISPLAY)
frame_count  out  16  number of completed frames, wrapping

Behaviour:
- Derived values: H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525). Both totals must be ≤1024; this is checked at elaboration and elaboration fails otherwise.
- Reset (async, rst_n=0): hpos=0, vpos=0, frame_count=0, display_on=1, all strobes=0, hsync and vsync at their inactive levels. No strobe fires on reset release.
- Advance, on a clk edge with ce=1:
  - If hpos<H_TOTAL-1, hpos increments.
  - Otherwise hpos wraps to 0 and vpos increments. When vpos is V_TOTAL-1 it wraps to 0 and frame_count increments (0xFFFF wraps to 0x0000).
- With ce=0, all counters and levels hold and all strobes are 0 on the next clk.
- All outputs are registered. The levels and strobes are computed from the next counter values, so every output is consistent with the hpos/vpos presented in the same cycle. The block adds no pipeline lag relative to the coordinates.
- hsync is active for H_DISPLAY+H_FRONT ≤ hpos < H_DISPLAY+H_FRONT+H_SYNC, i.e. hpos 656..751.
- vsync is active for V_DISPLAY+V_FRONT ≤ vpos < V_DISPLAY+V_FRONT+V_SYNC, i.e. vpos 490..491. vsync changes at hpos==0 edges only.
- Strobes are high for exactly one clk: the cycle following the ce-qualified advance that lands on the trigger position. They stay single-cycle even if ce then stays low and the counters hold.
- On the (V_TOTAL-1, H_TOTAL-1)→(0,0) advance, line_start and frame_start are both high, and frame_count shows its new value in that same cycle.
- A reset mid-frame immediately forces the reset values. After release, counting restarts at (0,0) and the first frame_start comes after one full frame.

Test Plan:
- Reset: hold rst_n=0 with ce=1 → hpos=0, vpos=0, hsync=1, vsync=1, display_on=1, frame_count=0, all strobes 0. Release → hpos=1 after the first edge and no strobe.
- Hsync window: ce=1 and run line 0 → hsync=1 at hpos 655, 0 at hpos 656..751, 1 at 752. display_on=0 from hpos 640. line_start is 1 exactly once, when hpos returns to 0 with vpos=1.
- Vertical: run a full frame → vsync=0 only for vpos 490..491. vblank_start is a single pulse at (0,480). display_on stays 0 for vpos 480..524.
- Frame wrap: from (524,799) advance once → (0,0) with frame_start=1, line_start=1 and frame_count=1. Run 65536 frames (or force frame_count=0xFFFF) → frame_count wraps to 0.
- ce gating: toggle ce 1-of-2 → counters advance every other clk. Hold ce=0 across (0,0) for 5 clks → frame_start is high for 1 clk only and hpos/vpos are frozen.
- Mid-frame reset: assert rst_n=0 at (300,400) → all outputs return to reset values asynchronously, before the next clk edge. No spurious frame_start after release.
